// File: rtl/my_bus_arbiter.sv
// Round-robin arbiter and sequencer that owns the master side of a shared
// valid/ready bus, holds the payload until accepted, and aborts stalled transfers.
module my_bus_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned TIMEOUT = 10
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ-1:0]        req_rw,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        req_err,
    output logic                      bus_valid,
    output logic [DATA_W-1:0]         bus_data,
    output logic [ADDR_W-1:0]         bus_addr,
    output logic                      bus_read_write,
    input  logic                      bus_ready,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      busy
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t              r_state;
    logic [IDX_W-1:0]    r_last;
    logic [CNT_W-1:0]    r_cnt;
    logic [NUM_REQ-1:0]  r_grant;
    logic [NUM_REQ-1:0]  r_req_ready;
    logic [NUM_REQ-1:0]  r_req_err;
    logic                r_bus_valid;
    logic                r_busy;
    logic [DATA_W-1:0]   r_bus_data;
    logic [ADDR_W-1:0]   r_bus_addr;
    logic                r_bus_rw;

    state_t              w_state_nxt;
    logic [IDX_W-1:0]    w_last_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [NUM_REQ-1:0]  w_grant_nxt;
    logic [NUM_REQ-1:0]  w_req_ready_nxt;
    logic [NUM_REQ-1:0]  w_req_err_nxt;
    logic                w_bus_valid_nxt;
    logic                w_busy_nxt;
    logic [DATA_W-1:0]   w_bus_data_nxt;
    logic [ADDR_W-1:0]   w_bus_addr_nxt;
    logic                w_bus_rw_nxt;

    logic                w_win_found;
    logic [IDX_W-1:0]    w_win_idx;
    logic [DATA_W-1:0]   w_data_arr [NUM_REQ];
    logic [ADDR_W-1:0]   w_addr_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_data_arr[g] = req_data[g*DATA_W +: DATA_W];
        assign w_addr_arr[g] = req_addr[g*ADDR_W +: ADDR_W];
    end

    // Round-robin search starting just after the last winner, wrapping around.
    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            if (!w_win_found && req_valid[IDX_W'((32'(r_last) + off) % NUM_REQ)]) begin
                w_win_found = 1'b1;
                w_win_idx   = IDX_W'((32'(r_last) + off) % NUM_REQ);
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_last_nxt      = r_last;
        w_cnt_nxt       = r_cnt;
        w_grant_nxt     = r_grant;
        w_req_ready_nxt = '0;
        w_req_err_nxt   = '0;
        w_bus_valid_nxt = r_bus_valid;
        w_busy_nxt      = r_busy;
        w_bus_data_nxt  = r_bus_data;
        w_bus_addr_nxt  = r_bus_addr;
        w_bus_rw_nxt    = r_bus_rw;

        case (r_state)
            ST_IDLE: begin
                if (w_win_found) begin
                    w_state_nxt            = ST_BUSY;
                    w_last_nxt             = w_win_idx;
                    w_cnt_nxt              = '0;
                    w_grant_nxt            = '0;
                    w_grant_nxt[w_win_idx] = 1'b1;
                    w_bus_valid_nxt        = 1'b1;
                    w_busy_nxt             = 1'b1;
                    w_bus_data_nxt         = w_data_arr[w_win_idx];
                    w_bus_addr_nxt         = w_addr_arr[w_win_idx];
                    w_bus_rw_nxt           = req_rw[w_win_idx];
                end
            end
            ST_BUSY: begin
                // Ready takes precedence over a watchdog expiry on the same edge.
                if (bus_ready) begin
                    w_state_nxt     = ST_IDLE;
                    w_req_ready_nxt = r_grant;
                    w_grant_nxt     = '0;
                    w_bus_valid_nxt = 1'b0;
                    w_busy_nxt      = 1'b0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt     = ST_IDLE;
                    w_req_ready_nxt = r_grant;
                    w_req_err_nxt   = r_grant;
                    w_grant_nxt     = '0;
                    w_bus_valid_nxt = 1'b0;
                    w_busy_nxt      = 1'b0;
                end else if (r_cnt != CNT_SAT) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_last      <= IDX_W'(NUM_REQ - 1);
            r_cnt       <= '0;
            r_grant     <= '0;
            r_req_ready <= '0;
            r_req_err   <= '0;
            r_bus_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_bus_data  <= '0;
            r_bus_addr  <= '0;
            r_bus_rw    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_last      <= w_last_nxt;
            r_cnt       <= w_cnt_nxt;
            r_grant     <= w_grant_nxt;
            r_req_ready <= w_req_ready_nxt;
            r_req_err   <= w_req_err_nxt;
            r_bus_valid <= w_bus_valid_nxt;
            r_busy      <= w_busy_nxt;
            r_bus_data  <= w_bus_data_nxt;
            r_bus_addr  <= w_bus_addr_nxt;
            r_bus_rw    <= w_bus_rw_nxt;
        end
    end

    assign req_ready      = r_req_ready;
    assign req_err        = r_req_err;
    assign bus_valid      = r_bus_valid;
    assign bus_data       = r_bus_data;
    assign bus_addr       = r_bus_addr;
    assign bus_read_write = r_bus_rw;
    assign grant          = r_grant;
    assign busy           = r_busy;

endmodule

// File: tb/tb_my_bus_arbiter.sv
// Self-checking bench for my_bus_arbiter: directed scenarios plus randomized
// traffic compared every cycle against a transaction-level reference model.
module tb_my_bus_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 8;
    localparam int unsigned TO = 10;

    logic             clk;
    logic             reset;
    logic [NR-1:0]    req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR*AW-1:0] req_addr;
    logic [NR-1:0]    req_rw;
    logic [NR-1:0]    req_ready;
    logic [NR-1:0]    req_err;
    logic             bus_valid;
    logic [DW-1:0]    bus_data;
    logic [AW-1:0]    bus_addr;
    logic             bus_read_write;
    logic             bus_ready;
    logic [NR-1:0]    grant;
    logic             busy;

    my_bus_arbiter #(
        .NUM_REQ(NR),
        .DATA_W (DW),
        .ADDR_W (AW),
        .TIMEOUT(TO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_addr      (req_addr),
        .req_rw        (req_rw),
        .req_ready     (req_ready),
        .req_err       (req_err),
        .bus_valid     (bus_valid),
        .bus_data      (bus_data),
        .bus_addr      (bus_addr),
        .bus_read_write(bus_read_write),
        .bus_ready     (bus_ready),
        .grant         (grant),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_bad;

    // Reference model: current owner (-1 when idle), last winner, cycles of valid so far.
    int            m_owner;
    int            m_last;
    int            m_elapsed;
    logic [DW-1:0] m_data;
    logic [AW-1:0] m_addr;
    logic          m_rw;
    logic [NR-1:0] e_rdy;
    logic [NR-1:0] e_err;

    int rr_seq [5] = '{0, 1, 2, 3, 0};
    int ph_req [5] = '{50, 90, 30, 100, 20};
    int ph_rdy [5] = '{50, 20, 0, 100, 90};

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner   = -1;
        m_last    = NR - 1;
        m_elapsed = 0;
        m_data    = '0;
        m_addr    = '0;
        m_rw      = 1'b0;
        e_rdy     = '0;
        e_err     = '0;
    endtask

    task automatic model_step();
        e_rdy = '0;
        e_err = '0;
        if (!reset) begin
            model_reset();
            return;
        end
        if (m_owner < 0) begin
            for (int k = 1; k <= NR; k++) begin
                int c;
                c = (m_last + k) % NR;
                if (m_owner < 0 && req_valid[c]) begin
                    m_owner   = c;
                    m_last    = c;
                    m_elapsed = 1;
                    m_data    = req_data[c*DW +: DW];
                    m_addr    = req_addr[c*AW +: AW];
                    m_rw      = req_rw[c];
                end
            end
        end else if (bus_ready) begin
            e_rdy[m_owner] = 1'b1;
            m_owner = -1;
        end else if (m_elapsed == TO) begin
            e_rdy[m_owner] = 1'b1;
            e_err[m_owner] = 1'b1;
            m_owner = -1;
        end else begin
            m_elapsed++;
        end
    endtask

    task automatic check_all();
        logic [NR-1:0] g;
        g = (m_owner >= 0) ? (NR'(1) << m_owner) : '0;
        chk("bus_valid", 64'(bus_valid), 64'(m_owner >= 0));
        chk("busy", 64'(busy), 64'(m_owner >= 0));
        chk("grant", 64'(grant), 64'(g));
        chk("req_ready", 64'(req_ready), 64'(e_rdy));
        chk("req_err", 64'(req_err), 64'(e_err));
        chk("bus_data", 64'(bus_data), 64'(m_data));
        chk("bus_addr", 64'(bus_addr), 64'(m_addr));
        chk("bus_rw", 64'(bus_read_write), 64'(m_rw));
    endtask

    // One clock: model follows the edge, outputs checked on the falling edge.
    task automatic run_cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic drive_random(input int p_req, input int p_rdy);
        for (int i = 0; i < NR; i++) begin
            req_valid[i]         = ($urandom_range(99) < p_req);
            req_rw[i]            = 1'($urandom);
            req_data[i*DW +: DW] = $urandom;
            req_addr[i*AW +: AW] = AW'($urandom);
        end
        bus_ready = ($urandom_range(99) < p_rdy);
    endtask

    task automatic drain();
        req_valid = '0;
        bus_ready = 1'b1;
        run_cycle();
        run_cycle();
        bus_ready = 1'b0;
    endtask

    initial begin
        int j;
        int cnt;
        bit done;
        n_vec = 0;
        n_bad = 0;
        reset     = 1'b0;
        req_valid = '0;
        req_rw    = '0;
        req_data  = '0;
        req_addr  = '0;
        bus_ready = 1'b0;
        model_reset();
        run_cycle();
        run_cycle();
        reset = 1'b1;

        // Fairness: everyone requesting, target always ready.
        req_valid = '1;
        bus_ready = 1'b1;
        j = 0;
        for (int n = 0; n < 10; n++) begin
            run_cycle();
            if (bus_valid && j < 5) begin
                chk("rr_grant", 64'(grant), 64'(NR'(1) << rr_seq[j]));
                j++;
            end
        end
        chk("rr_count", 64'(j), 64'(5));
        drain();

        // Single request, ready arrives on the fourth valid cycle.
        req_addr[2*AW +: AW] = 8'h3C;
        req_data[2*DW +: DW] = 32'hDEADBEEF;
        req_rw    = 4'b0100;
        req_valid = 4'b0100;
        bus_ready = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            run_cycle();
            chk("sr_valid", 64'(bus_valid), 64'(1));
            chk("sr_addr", 64'(bus_addr), 64'h3C);
            chk("sr_data", 64'(bus_data), 64'hDEADBEEF);
            chk("sr_rw", 64'(bus_read_write), 64'(1));
            chk("sr_grant", 64'(grant), 64'(4'b0100));
            if (n == 4) bus_ready = 1'b1;
        end
        run_cycle();
        chk("sr_rdy", 64'(req_ready), 64'(4'b0100));
        chk("sr_err", 64'(req_err), 64'(0));
        chk("sr_vlow", 64'(bus_valid), 64'(0));
        req_valid = '0;
        bus_ready = 1'b0;

        // Timeout with the target stuck.
        req_valid = 4'b0010;
        cnt  = 0;
        done = 1'b0;
        for (int n = 0; n < 3*TO && !done; n++) begin
            run_cycle();
            if (bus_valid) cnt++;
            if (req_ready != '0) done = 1'b1;
        end
        chk("to_len", 64'(cnt), 64'(TO));
        chk("to_rdy", 64'(req_ready), 64'(4'b0010));
        chk("to_err", 64'(req_err), 64'(4'b0010));
        req_valid = 4'b0001;
        bus_ready = 1'b1;
        run_cycle();
        chk("to_next_grant", 64'(grant), 64'(4'b0001));
        run_cycle();
        chk("to_next_rdy", 64'(req_ready), 64'(4'b0001));
        chk("to_next_err", 64'(req_err), 64'(0));
        req_valid = '0;
        bus_ready = 1'b0;

        // Ready arrives on the edge that would otherwise time out.
        req_valid = 4'b0010;
        cnt  = 0;
        done = 1'b0;
        for (int n = 0; n < 3*TO && !done; n++) begin
            run_cycle();
            if (bus_valid) cnt++;
            if (req_ready != '0) done = 1'b1;
            else if (cnt == TO) bus_ready = 1'b1;
        end
        chk("rte_len", 64'(cnt), 64'(TO));
        chk("rte_rdy", 64'(req_ready), 64'(4'b0010));
        chk("rte_err", 64'(req_err), 64'(0));
        req_valid = '0;
        bus_ready = 1'b0;

        // Asynchronous reset in the middle of a stalled transaction.
        req_valid = 4'b0100;
        run_cycle();
        run_cycle();
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        chk("ar_valid", 64'(bus_valid), 64'(0));
        chk("ar_grant", 64'(grant), 64'(0));
        chk("ar_busy", 64'(busy), 64'(0));
        chk("ar_data", 64'(bus_data), 64'(0));
        chk("ar_addr", 64'(bus_addr), 64'(0));
        run_cycle();
        run_cycle();
        reset     = 1'b1;
        req_valid = 4'b1001;
        bus_ready = 1'b1;
        run_cycle();
        chk("ar_first", 64'(grant), 64'(4'b0001));

        // Priority wrap after requester 3 wins.
        run_cycle();
        req_valid = 4'b1000;
        run_cycle();
        chk("pw_g3", 64'(grant), 64'(4'b1000));
        run_cycle();
        req_valid = 4'b0110;
        run_cycle();
        chk("pw_g1", 64'(grant), 64'(4'b0010));
        run_cycle();
        req_valid = 4'b0100;
        run_cycle();
        chk("pw_g2", 64'(grant), 64'(4'b0100));
        run_cycle();
        req_valid = '0;
        bus_ready = 1'b0;

        // Randomized traffic at several request/ready densities.
        for (int ph = 0; ph < 5; ph++) begin
            for (int n = 0; n < 250; n++) begin
                drive_random(ph_req[ph], ph_rdy[ph]);
                run_cycle();
            end
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/my_bus_arbiter.md
# my_bus_arbiter

Round-robin arbiter and sequencer that shares the single valid/ready transaction bus (32-bit data, 8-bit addr, read_write) among NUM_REQ requesters. It sits between the requesting agents and the bus interface and owns the bus master side: valid, data, addr and read_write. It holds the payload stable until the target accepts it, and a watchdog aborts any transaction the target never acknowledges.

## Interface
- NUM_REQ, 4: number of requesters; legal range 2..16.
- DATA_W, 32: bus data width.
- ADDR_W, 8: bus address width.
- TIMEOUT, 10: maximum wait cycles for bus_ready after bus_valid rises; legal range ≥1.
- clk  input  1  bus clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low; the block is in reset while reset==0.
- req_valid  input  NUM_REQ  per-requester transaction request; held until that requester's req_ready pulse.
- req_data  input  NUM_REQ*DATA_W  per-requester write data; slice i is bits [i*DATA_W +: DATA_W].
- req_addr  input  NUM_REQ*ADDR_W  per-requester address.
- req_rw  input  NUM_REQ  per-requester read_write (1 = write).
- req_ready  output  NUM_REQ  one-cycle completion pulse to the granted requester.
- req_err  output  NUM_REQ  one-cycle timeout flag, coincident with req_ready.
- bus_valid  output  1  bus valid.
- bus_data  output  DATA_W  bus data.
- bus_addr  output  ADDR_W  bus address.
- bus_read_write  output  1  bus read_write.
- bus_ready  input  1  bus ready from the target.
- grant  output  NUM_REQ  one-hot current owner; all zeros when idle.
- busy  output  1  high while the state is BUSY.

## Operation
- The FSM has two states:
  - IDLE: bus_valid=0, grant=0.
  - BUSY: bus_valid=1, grant is one-hot.
- IDLE to BUSY, on the first edge where any req_valid bit is 1:
  - The winner is picked round-robin, searching from (last+1) mod NUM_REQ upward with wrap.
  - The winner's data, addr and rw are registered into bus_data, bus_addr and bus_read_write.
  - last is set to the winner, grant is set to the winner's one-hot, and the wait counter clears to 0.
- In BUSY, each edge with bus_ready==0 increments the wait counter, which saturates at TIMEOUT. The bus payload registers are not written while in BUSY, so the payload stays stable while valid && !ready.
- BUSY to IDLE, normal: on an edge with bus_ready==1, req_ready[g] pulses for one cycle, req_err stays 0, and bus_valid drops.
- BUSY to IDLE, timeout: on an edge where bus_ready==0 and the counter already equals TIMEOUT-1:
  - req_ready[g] and req_err[g] both pulse for one cycle.
  - bus_valid drops.
  - The transaction is discarded with no retry.
- If bus_ready==1 arrives on the same edge that would time out, the ready wins: normal completion with req_err=0.
- There is always at least one IDLE cycle between transactions. Throughput is therefore one transaction per (wait cycles + 2).
- req_valid changing while BUSY has no effect on the current transaction. A requester deasserting req_valid before its grant simply drops out of arbitration.
- bus_data, bus_addr and bus_read_write keep their last values while IDLE, so nothing toggles.
- Reset while reset==0, applied immediately:
  - Cleared to 0: state=IDLE, bus_valid, bus_data, bus_addr, bus_read_write, grant, req_ready, req_err, busy, and the counter.
  - last resets to NUM_REQ-1, so requester 0 has first priority.
  - An in-flight transaction is lost without a req_ready pulse.

## Timing
- All outputs are registered, and outputs are driven from registers only. No combinational path exists from any input to any output.
- Grant latency: req_valid high, sampled at edge k, gives bus_valid and grant high after edge k.
- Completion latency: bus_ready high at edge m gives req_ready and req_err visible after edge m for exactly one cycle, and bus_valid low after edge m.
- Timeout: with bus_valid rising after edge k and ready never arriving, bus_valid falls and req_err pulses after edge k+TIMEOUT. That is TIMEOUT cycles of bus_valid high, satisfying a ready-within-[1:TIMEOUT] check.
- Reset deassertion is synchronised externally. The first arbitration happens on the first clk edge with reset==1.

## Test plan
- Single request: req_valid=4'b0100, req_addr[2]=8'h3C, req_data[2]=32'hDEADBEEF, rw=1, bus_ready high 3 cycles after valid → bus carries 8'h3C/32'hDEADBEEF/1 stable for 4 cycles of valid, grant=4'b0100, one req_ready[2] pulse, req_err=0.
- Round-robin fairness: all four req_valid held high, bus_ready tied 1 → grants in order 0,1,2,3,0, each valid high exactly 1 cycle with 1 IDLE cycle between.
- Timeout: req 1 valid, bus_ready stuck 0, TIMEOUT=10 → bus_valid high exactly 10 cycles, then req_ready[1]=req_err[1]=1 for one cycle, next grant proceeds normally.
- Ready on timeout edge: bus_ready asserted on the 10th cycle of valid → normal completion, req_err=0.
- Reset mid-transaction: reset driven low 2 cycles into BUSY with ready=0 → all outputs 0 immediately without waiting for clk, no req_ready pulse. After release, with requests 4'b1001 → requester 0 granted first.
- Priority wrap: last grant=3, req_valid=4'b0110 → requester 1 granted, then requester 2.
